// File: rtl/uart_rx_if.sv
// Serial receive bundle: the rx line plus the received-byte strobes and status.
// master drives the line, slave is the receiver.
interface uart_rx_if #(
  parameter int unsigned DATA_LEN = 8
);
  logic                rx;
  logic [DATA_LEN-1:0] data_out;
  logic                receive_sig;
  logic                rx_busy;
  logic                frame_err;

  modport master (
    output rx,
    input  data_out,
    input  receive_sig,
    input  rx_busy,
    input  frame_err
  );

  modport slave (
    input  rx,
    output data_out,
    output receive_sig,
    output rx_busy,
    output frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: synchronizes rx, detects a start bit at its midpoint,
// shifts in DATA_LEN bits LSB first and checks the stop bit.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned DATA_LEN     = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LEN - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic                sync1, rx_s;
  logic [2:0]          state, state_nxt;
  logic [CNT_W-1:0]    clk_cnt, cnt_nxt;
  logic [IDX_W-1:0]    bit_idx, idx_nxt;
  logic [DATA_LEN-1:0] shift_q, shift_nxt;
  logic [DATA_LEN-1:0] data_q, data_nxt;
  logic                recv_q, recv_nxt;
  logic                ferr_q, ferr_nxt;

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      data_q  <= '0;
      recv_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1   <= bus.rx;
      rx_s    <= sync1;
      state   <= state_nxt;
      clk_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shift_q <= shift_nxt;
      data_q  <= data_nxt;
      recv_q  <= recv_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift_q;
    data_nxt  = data_q;
    recv_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        // A start bit that is gone by its midpoint is a line glitch.
        if (clk_cnt == CNT_MID) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift_q;
            recv_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        // Hold through a break so it reports a single frame error.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  assign bus.data_out    = data_q;
  assign bus.receive_sig = recv_q;
  assign bus.frame_err   = ferr_q;
  assign bus.rx_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=4: the stimulus queues expected
// strobes, a negedge monitor pops and checks them as the receiver reports.
module tb_uart_rx;

  localparam int unsigned CPB = 4;
  localparam int unsigned DL  = 8;

  typedef struct packed {
    logic        is_err;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic  clk;
  logic  reset;
  int    cyc;
  int    applied;
  int    miscompares;
  logic  prev_pulse;
  exp_t  sb[$];
  exp_t  mon_e;

  uart_rx_if #(.DATA_LEN(DL)) bus ();

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_LEN    (DL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every strobe must match the head of the scoreboard.
  initial prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (reset && (bus.receive_sig || bus.frame_err)) begin
      chk("pulse_exclusive", 32'(bus.receive_sig & bus.frame_err), 32'd0);
      chk("pulse_width", 32'(prev_pulse), 32'd0);
      if (sb.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_pulse: receive_sig=%0b frame_err=%0b, none expected (cycle %0d)",
                 bus.receive_sig, bus.frame_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind_frame_err", 32'(bus.frame_err), 32'(mon_e.is_err));
        chk("data_out_at_pulse", 32'(bus.data_out), 32'(mon_e.data));
        applied++;
        if (cyc < int'(mon_e.cyc) - 1 || cyc > int'(mon_e.cyc) + 1) begin
          miscompares++;
          $display("FAIL pulse_latency: pulse at cycle %0d, expected %0d +/-1", cyc, mon_e.cyc);
        end
      end
    end
    prev_pulse = reset & (bus.receive_sig | bus.frame_err);
  end

  // One frame starting at the current negedge; the strobe is due 2 sync cycles
  // plus (CPB-1)/2 + 1 + 9*CPB cycles after rx falls.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic [7:0] exp_data);
    exp_t e;
    e.is_err = ~stop_bit;
    e.data   = exp_data;
    e.cyc    = 32'(cyc + 2 + (CPB - 1) / 2 + 1 + 9 * CPB);
    sb.push_back(e);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] partial;
    applied     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.rx      = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data_out", 32'(bus.data_out), 32'd0);
    chk("reset_receive_sig", 32'(bus.receive_sig), 32'd0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
    chk("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single good frame
    send_frame(8'hCC, 1'b1, 8'hCC);
    drain();
    repeat (4) @(negedge clk);
    chk("cc_data_out", 32'(bus.data_out), 32'hCC);
    chk("cc_idle_busy", 32'(bus.rx_busy), 32'd0);

    // One-clock glitch: brief START visit then back to IDLE silently
    bus.rx = 1'b0;
    @(negedge clk);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_in_start", 32'(bus.rx_busy), 32'd1);
    repeat (10) @(negedge clk);
    chk("glitch_busy_cleared", 32'(bus.rx_busy), 32'd0);
    chk("glitch_data_out", 32'(bus.data_out), 32'hCC);

    // Bad stop bit followed by a 3-bit-time break
    send_frame(8'h5A, 1'b0, 8'hCC);
    repeat (3 * CPB) @(negedge clk);
    chk("break_busy_held", 32'(bus.rx_busy), 32'd1);
    chk("break_data_kept", 32'(bus.data_out), 32'hCC);
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_busy_released", 32'(bus.rx_busy), 32'd0);
    drain();

    // Back-to-back frames with no idle gap
    send_frame(8'h55, 1'b1, 8'h55);
    send_frame(8'hA3, 1'b1, 8'hA3);
    drain();
    repeat (4) @(negedge clk);
    chk("b2b_final_data", 32'(bus.data_out), 32'hA3);

    // Reset during data bit 4, then a clean frame
    partial = 8'hF0;
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.rx = partial[i];
      repeat (CPB) @(negedge clk);
    end
    chk("midframe_busy", 32'(bus.rx_busy), 32'd1);
    reset  = 1'b0;
    bus.rx = 1'b1;
    @(negedge clk);
    chk("midreset_data_out", 32'(bus.data_out), 32'd0);
    chk("midreset_rx_busy", 32'(bus.rx_busy), 32'd0);
    chk("midreset_receive_sig", 32'(bus.receive_sig), 32'd0);
    chk("midreset_frame_err", 32'(bus.frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h01, 1'b1, 8'h01);
    drain();
    repeat (4) @(negedge clk);
    chk("post_reset_data", 32'(bus.data_out), 32'h01);
    chk("post_reset_idle", 32'(bus.rx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2604: clk cycles per serial bit; legal values are 4 or more.
REQ-002 Parameter DATA_LEN, default 8: data bits per frame.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006 data_out  output  DATA_LEN  last correctly framed byte; feeds the bridge's u_data_in.
REQ-007 receive_sig  output  1  one-cycle pulse when data_out is updated; feeds the bridge's u_receive_sig.
REQ-008 rx_busy  output  1  high whenever the state is not IDLE.
REQ-009 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.

Function
REQ-010 rx SHALL pass through a two-flop synchronizer (rx_s); both flops reset to 1; all decisions use rx_s only.
REQ-011 The FSM SHALL have exactly these states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 One bit counter, clk_cnt, SHALL range 0..CLKS_PER_BIT-1, with width clog2(CLKS_PER_BIT).
REQ-013 One index counter, bit_idx, SHALL range 0..DATA_LEN-1.
REQ-014 IDLE: on rx_s==0 go to START, clk_cnt=0; otherwise stay.
REQ-015 START: clk_cnt increments each cycle.
REQ-016 START at clk_cnt==(CLKS_PER_BIT-1)/2: if rx_s==0, go to DATA with clk_cnt=0 and bit_idx=0.
REQ-017 START at clk_cnt==(CLKS_PER_BIT-1)/2: if rx_s==1, treat as a glitch and return to IDLE with no output activity.
REQ-018 DATA: at clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift-register bit bit_idx (LSB first) and reset clk_cnt.
REQ-019 DATA: after the sample with bit_idx==DATA_LEN-1, go to STOP; otherwise increment bit_idx.
REQ-020 STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
REQ-021 STOP sample ==1: in the same cycle, load data_out with the shift register, pulse receive_sig for 1 cycle, and go to IDLE.
REQ-022 STOP sample ==0: pulse frame_err for 1 cycle, leave data_out unchanged, do not pulse receive_sig, and go to WAIT_IDLE.
REQ-023 WAIT_IDLE: stay until rx_s==1, then go to IDLE; a line held low (break) SHALL produce exactly one frame_err.
REQ-024 Latency: the receive_sig pulse occurs (CLKS_PER_BIT-1)/2 + 1 + (DATA_LEN+1)*CLKS_PER_BIT cycles after the first cycle rx_s==0 is seen in IDLE, within ±1 cycle.
REQ-025 Back-to-back frames: the return to IDLE at mid-stop-bit SHALL allow a start bit beginning immediately after the stop bit to be captured.
REQ-026 receive_sig and frame_err SHALL never be high in the same cycle, and neither SHALL be high for 2 consecutive cycles.
REQ-027 rx_busy SHALL be combinationally equal to (state != IDLE).
REQ-028 Illegal state encodings SHALL return to IDLE on the next clock, with all counters cleared.

Reset
REQ-029 While reset==0: state=IDLE, clk_cnt=0, bit_idx=0, shift register=0, data_out=0, receive_sig=0, frame_err=0, rx_busy=0, both synchronizer flops=1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no receive_sig or frame_err pulse.
REQ-031 After reset release, the first start bit is detected only after rx_s has been observed high at least once (IDLE entry from reset treats rx_s==1 as established).

Verification (CLKS_PER_BIT=4)
REQ-032 Frame 0xCC with a valid stop bit -> data_out=0xCC, receive_sig high exactly 1 cycle at the REQ-024 latency, frame_err=0.
REQ-033 rx low for 1 clk then high (glitch) -> state returns to IDLE, no receive_sig or frame_err, data_out unchanged.
REQ-034 Frame 0x5A with a stop bit of 0, rx then held low for 3 bit times -> one frame_err pulse, data_out keeps its prior value, rx_busy stays high until rx returns high.
REQ-035 Frames 0x55 and 0xA3 sent back-to-back with no idle gap -> two receive_sig pulses, data_out=0x55 then 0xA3.
REQ-036 reset driven to 0 during bit 4 of a frame, then released with rx idle -> all outputs at reset values, no pulses, and the next frame 0x01 is received correctly.
